// File: rtl/regfile_dump_reader.sv
// Hardware dump engine for the 16x32 register file: walks one read port over a
// wrapping index range and streams each value out on a valid/ready interface.
module regfile_dump_reader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur, lst;
  logic [ADDR_W-1:0] cur_inc;
  logic              hs;

  assign hs      = out_valid && out_ready;
  assign cur_inc = (cur == ADDR_W'(NUM_REGS - 1)) ? '0 : cur + ADDR_W'(1);

  // cur is itself a register, so the read select is a registered copy of it
  assign rd_sel = cur;
  assign busy   = (state != IDLE);
  assign done   = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = abort ? IDLE : SEND;
      SEND: begin
        // abort wins over the handshake; a beat accepted alongside abort still counts
        if (abort)   state_nxt = IDLE;
        else if (hs) state_nxt = (cur == lst) ? FIN : FETCH;
      end
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      lst       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur <= first_idx;
            lst <= last_idx;
          end
        end
        FETCH: begin
          if (!abort) begin
            out_data  <= rd_data;
            out_idx   <= cur;
            out_last  <= (cur == lst);
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
          end else if (hs) begin
            out_valid <= 1'b0;
            if (cur != lst) cur <= cur_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats are queued when a dump
// is started and retired against accepted output beats.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  first_idx, last_idx;
  logic        abort;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [16];
  assign rd_data = regs[rd_sel];

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rd_sel(rd_sel), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    n_checks = 0;
  int    n_err    = 0;
  int    beats    = 0;
  int    dones    = 0;
  bit    rnd_ready = 1'b0;
  bit    prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_range(input int f, input int l);
    int n;
    beat_t b;
    n = ((l - f + 16) % 16) + 1;
    for (int k = 0; k < n; k++) begin
      b.idx  = 4'((f + k) % 16);
      b.data = 32'hFFFFFF00 + 32'(b.idx);
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Ready is changed just after each rising edge so it is stable at the sample point.
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) check("rdsel_eq_cur", 64'(rd_sel), 64'(out_idx));
      if (prev_stall && out_valid) begin
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_idx", 64'(out_idx), 64'(prev_idx));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) check("extra_beat", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("beat_idx", 64'(out_idx), 64'(e.idx));
          check("beat_data", 64'(out_data), 64'(e.data));
          check("beat_last", 64'(out_last), 64'(e.last));
        end
      end
      if (done) dones++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_sel"}, 64'(rd_sel), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_data"}, 64'(out_data), 64'(0));
    check({tag, "_idx"}, 64'(out_idx), 64'(0));
    check({tag, "_last"}, 64'(out_last), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // exp_busy < 0 skips the busy-length check (used under random backpressure).
  task automatic do_dump(input string tag, input int f, input int l, input int exp_busy,
                         input int spur);
    int cycles, b0, d0, n;
    n  = ((l - f + 16) % 16) + 1;
    b0 = beats;
    d0 = dones;
    push_range(f, l);
    @(posedge clk); #1;
    start = 1'b1; first_idx = 4'(f); last_idx = 4'(l);
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 400) begin
      cycles++;
      if (cycles == 2) check({tag, "_valid_latency"}, 64'(out_valid), 64'(1));
      if (spur != 0 && cycles == spur) begin
        start = 1'b1; first_idx = 4'd3; last_idx = 4'd4;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (cycles >= 400) check({tag, "_timeout"}, 64'(cycles), 64'(0));
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(cycles), 64'(exp_busy));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_beats"}, 64'(beats - b0), 64'(n));
    check({tag, "_dones"}, 64'(dones - d0), 64'(1));
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int b0, d0, n;
    for (int i = 0; i < 16; i++) regs[i] = 32'hFFFFFF00 + 32'(i);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; first_idx = '0; last_idx = '0;
    out_ready = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;

    do_dump("full", 0, 15, 33, 0);
    rnd_ready = 1'b1;
    do_dump("bp", 0, 15, -1, 0);
    rnd_ready = 1'b0;
    do_dump("wrap", 14, 1, 9, 0);
    do_dump("single", 5, 5, 3, 0);
    do_dump("busy_start", 0, 15, 33, 7);
    do_dump("bp_wrap", 9, 8, 33, 0);

    // abort while beat 6 is being accepted
    b0 = beats; d0 = dones;
    push_range(0, 15);
    @(posedge clk); #1;
    start = 1'b1; first_idx = 4'd0; last_idx = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 4'd6) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("abort_wait_timeout", 64'(n), 64'(0));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    check("abort_beats", 64'(beats - b0), 64'(7));
    check("abort_no_done", 64'(dones - d0), 64'(0));
    check("abort_q_left", 64'(exp_q.size()), 64'(9));
    exp_q.delete();

    // asynchronous reset mid-dump
    push_range(0, 15);
    @(posedge clk); #1;
    start = 1'b1; first_idx = 4'd0; last_idx = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    do_dump("after_rst", 2, 3, 5, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
